drive_supervisor: RTL and testbench

//  Parametrised successor to the single-cycle overheat/arrival/fuel decision logic.

---
 rtl/drive_supervisor_pkg.sv | 25 ++
 rtl/sup_debounce.sv | 42 ++++
 rtl/drive_supervisor.sv | 226 ++++++++++++++++++++++
 tb/tb_drive_supervisor.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drive_supervisor_pkg.sv
// ---------------------------------------------------------------------------
// drive_supervisor_pkg
//   Shared state encodings and widths for the drive supervisor.
//   drv_state_t : IDLE=0 DRIVE=1 PARKED=2 EMPTY=3 (value driven on drive_state_o)
//   th_state_t  : OK=0 HOT=1 COOL=2               (value driven on therm_state_o)
// ---------------------------------------------------------------------------
package drive_supervisor_pkg;

    localparam int DRV_STATE_W = 2;
    localparam int TH_STATE_W  = 2;

    typedef enum logic [DRV_STATE_W-1:0] {
        DRV_IDLE   = 2'd0,
        DRV_DRIVE  = 2'd1,
        DRV_PARKED = 2'd2,
        DRV_EMPTY  = 2'd3
    } drv_state_t;

    typedef enum logic [TH_STATE_W-1:0] {
        TH_OK   = 2'd0,
        TH_HOT  = 2'd1,
        TH_COOL = 2'd2
    } th_state_t;

endpackage

// File: rtl/sup_debounce.sv
// ---------------------------------------------------------------------------
// sup_debounce
//   Consecutive-cycle qualifier. fire_o is high on the edge where cond_i has
//   been sampled true for DEBOUNCE consecutive cycles (DEBOUNCE=1 gives a
//   plain registered decision on the first true sample).
//   Ports:
//     clk     in  clock, rising edge
//     rst_n   in  asynchronous active-low reset
//     cond_i  in  condition being qualified
//     clr_i   in  owning FSM is not in the state that uses this qualifier
//     fire_o  out condition has held long enough (combinational on r_cnt)
// ---------------------------------------------------------------------------
module sup_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cond_i,
    input  logic clr_i,
    output logic fire_o
);

    // The counter only needs to reach DEBOUNCE-1; the final qualifying
    // sample is the one that fires.
    localparam int              CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr_i || !cond_i) begin
            r_cnt <= '0;
        end else if (r_cnt != LAST) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign fire_o = cond_i & ~clr_i & (r_cnt == LAST);

endmodule

// File: rtl/drive_supervisor.sv
// ---------------------------------------------------------------------------
// drive_supervisor
//   Supervises N_TEMP temperature channels (debounced overheat shutdown with
//   hysteresis and cooldown) and the vehicle drive state (start, arrival,
//   fuel-empty stop, refuel resume). The two FSMs are fully independent.
//   Optional feature macro: OVERHEAT_CNT_EN (saturating OK->HOT counter).
//   Ports:
//     clk                 in  clock, rising edge
//     rst_n               in  asynchronous active-low reset
//     temp_i              in  N_TEMP*TEMP_W, channel k at [k*TEMP_W +: TEMP_W]
//     arrived_i           in  destination reached
//     fuel_level_i        in  FUEL_W fuel level
//     start_i             in  drive request (level)
//     shut_off_computer_o out thermal state is not OK
//     keep_driving_o      out drive state is DRIVE
//     drive_state_o       out 2-bit drive state
//     therm_state_o       out 2-bit thermal state
//     overheat_cnt_o      out saturating overheat count (0 when feature off)
// ---------------------------------------------------------------------------
module drive_supervisor
    import drive_supervisor_pkg::*;
#(
    parameter int N_TEMP      = 4,
    parameter int TEMP_W      = 8,
    parameter int FUEL_W      = 8,
    parameter int TEMP_HI     = 90,
    parameter int TEMP_LO     = 70,
    parameter int FUEL_MIN    = 5,
    parameter int FUEL_RESUME = 20,
    parameter int DEBOUNCE    = 4,
    parameter int COOLDOWN    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_TEMP*TEMP_W-1:0] temp_i,
    input  logic                     arrived_i,
    input  logic [FUEL_W-1:0]        fuel_level_i,
    input  logic                     start_i,
    output logic                     shut_off_computer_o,
    output logic                     keep_driving_o,
    output logic [DRV_STATE_W-1:0]   drive_state_o,
    output logic [TH_STATE_W-1:0]    therm_state_o,
    output logic [7:0]               overheat_cnt_o
);

    localparam int               CD_W    = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [CD_W-1:0]  CD_LAST = CD_W'(COOLDOWN - 1);

    // ---------------- temperature classification ----------------
    logic [N_TEMP-1:0] w_ch_hot;
    logic [N_TEMP-1:0] w_ch_cool;
    logic [N_TEMP:0]   w_any_chain;
    logic [N_TEMP:0]   w_all_chain;
    logic              w_any_hot;
    logic              w_all_cool;

    assign w_any_chain[0] = 1'b0;
    assign w_all_chain[0] = 1'b1;

    genvar k;
    generate
        for (k = 0; k < N_TEMP; k++) begin : g_chan
            assign w_ch_hot[k]      = temp_i[k*TEMP_W +: TEMP_W] >= TEMP_W'(TEMP_HI);
            assign w_ch_cool[k]     = temp_i[k*TEMP_W +: TEMP_W] <= TEMP_W'(TEMP_LO);
            assign w_any_chain[k+1] = w_any_chain[k] | w_ch_hot[k];
            assign w_all_chain[k+1] = w_all_chain[k] & w_ch_cool[k];
        end
    endgenerate

    assign w_any_hot  = w_any_chain[N_TEMP];
    assign w_all_cool = w_all_chain[N_TEMP];

    // ---------------- drive conditions ----------------
    logic w_go;
    logic w_fuel_low;
    logic w_fuel_ok;

    assign w_go       = start_i & ~arrived_i & (fuel_level_i > FUEL_W'(FUEL_MIN));
    assign w_fuel_low = fuel_level_i <= FUEL_W'(FUEL_MIN);
    assign w_fuel_ok  = fuel_level_i >= FUEL_W'(FUEL_RESUME);

    // ---------------- state registers ----------------
    th_state_t       r_therm;
    drv_state_t      r_drive;
    logic [CD_W-1:0] r_cool_cnt;
    logic            r_shut;
    logic            r_keep;

    // ---------------- debouncers ----------------
    logic w_hot_fire;
    logic w_arr_fire;
    logic w_emp_fire;

    sup_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_hot (
        .clk    (clk),
        .rst_n  (rst_n),
        .cond_i (w_any_hot),
        .clr_i  (r_therm != TH_OK),
        .fire_o (w_hot_fire)
    );

    sup_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_arr (
        .clk    (clk),
        .rst_n  (rst_n),
        .cond_i (arrived_i),
        .clr_i  (r_drive != DRV_DRIVE),
        .fire_o (w_arr_fire)
    );

    sup_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_emp (
        .clk    (clk),
        .rst_n  (rst_n),
        .cond_i (w_fuel_low),
        .clr_i  (r_drive != DRV_DRIVE),
        .fire_o (w_emp_fire)
    );

    // ---------------- thermal FSM ----------------
    // Readings between TEMP_LO and TEMP_HI change nothing in HOT or COOL,
    // and freeze the cooldown count in COOL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_therm    <= TH_OK;
            r_cool_cnt <= '0;
            r_shut     <= 1'b0;
        end else begin
            case (r_therm)
                TH_OK: begin
                    if (w_hot_fire) begin
                        r_therm <= TH_HOT;
                        r_shut  <= 1'b1;
                    end
                end
                TH_HOT: begin
                    if (w_all_cool) begin
                        r_therm    <= TH_COOL;
                        r_cool_cnt <= '0;
                    end
                end
                TH_COOL: begin
                    if (w_any_hot) begin
                        r_therm <= TH_HOT;
                    end else if (w_all_cool) begin
                        if (r_cool_cnt == CD_LAST) begin
                            r_therm <= TH_OK;
                            r_shut  <= 1'b0;
                        end else begin
                            r_cool_cnt <= r_cool_cnt + CD_W'(1);
                        end
                    end
                end
                default: begin
                    r_therm <= TH_OK;
                    r_shut  <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- drive FSM ----------------
    // Arrival is tested first so it wins when both debouncers fire together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drive <= DRV_IDLE;
            r_keep  <= 1'b0;
        end else begin
            case (r_drive)
                DRV_IDLE: begin
                    if (w_go) begin
                        r_drive <= DRV_DRIVE;
                        r_keep  <= 1'b1;
                    end
                end
                DRV_DRIVE: begin
                    if (w_arr_fire) begin
                        r_drive <= DRV_PARKED;
                        r_keep  <= 1'b0;
                    end else if (w_emp_fire) begin
                        r_drive <= DRV_EMPTY;
                        r_keep  <= 1'b0;
                    end
                end
                DRV_PARKED: begin
                    if (w_go) begin
                        r_drive <= DRV_DRIVE;
                        r_keep  <= 1'b1;
                    end else if (!start_i && !arrived_i) begin
                        r_drive <= DRV_IDLE;
                    end
                end
                DRV_EMPTY: begin
                    if (w_fuel_ok) begin
                        r_drive <= DRV_IDLE;
                    end
                end
                default: begin
                    r_drive <= DRV_IDLE;
                    r_keep  <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- overheat event counter ----------------
`ifdef OVERHEAT_CNT_EN
    logic [7:0] r_ovh_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovh_cnt <= 8'd0;
        end else if (w_hot_fire && (r_therm == TH_OK) && (r_ovh_cnt != 8'hFF)) begin
            r_ovh_cnt <= r_ovh_cnt + 8'd1;
        end
    end

    assign overheat_cnt_o = r_ovh_cnt;
`else
    assign overheat_cnt_o = 8'd0;
`endif

    assign shut_off_computer_o = r_shut;
    assign keep_driving_o      = r_keep;
    assign drive_state_o       = r_drive;
    assign therm_state_o       = r_therm;

endmodule

// File: tb/tb_drive_supervisor.sv
module tb_drive_supervisor;

    localparam int N_TEMP      = 4;
    localparam int TEMP_HI     = 90;
    localparam int TEMP_LO     = 70;
    localparam int FUEL_MIN    = 5;
    localparam int FUEL_RESUME = 20;
    localparam int DEBOUNCE    = 4;
    localparam int COOLDOWN    = 16;
`ifdef OVERHEAT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] temp = '0;
    logic        arrived = 1'b0;
    logic [7:0]  fuel = 8'd50;
    logic        start = 1'b0;

    logic        shut_off, keep_drv;
    logic [1:0]  drv_st, th_st;
    logic [7:0]  ovh_cnt;
    logic [13:0] w_obs;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model state: 0=OK 1=HOT 2=COOL ; 0=IDLE 1=DRIVE 2=PARKED 3=EMPTY
    int m_th, m_dr, m_hot_run, m_arr_run, m_emp_run, m_cool, m_ovh;

    drive_supervisor dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .temp_i              (temp),
        .arrived_i           (arrived),
        .fuel_level_i        (fuel),
        .start_i             (start),
        .shut_off_computer_o (shut_off),
        .keep_driving_o      (keep_drv),
        .drive_state_o       (drv_st),
        .therm_state_o       (th_st),
        .overheat_cnt_o      (ovh_cnt)
    );

    always #5 clk = ~clk;

    assign w_obs = {shut_off, keep_drv, drv_st, th_st, ovh_cnt};

    function automatic void model_reset();
        m_th = 0; m_dr = 0; m_hot_run = 0; m_arr_run = 0; m_emp_run = 0; m_cool = 0; m_ovh = 0;
    endfunction

    // One clock edge of the specified behaviour, using the inputs sampled at that edge.
    function automatic void model_step();
        bit any_hot = 1'b0;
        bit all_cool = 1'b1;
        bit go;
        int nth, ndr, t;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < N_TEMP; k++) begin
            t = int'(temp[k*8 +: 8]);
            if (t >= TEMP_HI) any_hot = 1'b1;
            if (t > TEMP_LO) all_cool = 1'b0;
        end
        go  = start && !arrived && (int'(fuel) > FUEL_MIN);
        nth = m_th;
        ndr = m_dr;
        if (m_th == 0) begin
            m_hot_run = any_hot ? m_hot_run + 1 : 0;
            if (m_hot_run >= DEBOUNCE) begin
                nth = 1;
                m_ovh++;
            end
        end else if (m_th == 1) begin
            if (all_cool) begin
                nth = 2;
                m_cool = 0;
            end
        end else begin
            if (any_hot) nth = 1;
            else if (all_cool) begin
                if (m_cool == COOLDOWN - 1) nth = 0;
                else m_cool++;
            end
        end
        if (nth != 0) m_hot_run = 0;
        if (m_dr == 0) begin
            if (go) ndr = 1;
        end else if (m_dr == 1) begin
            m_arr_run = arrived ? m_arr_run + 1 : 0;
            m_emp_run = (int'(fuel) <= FUEL_MIN) ? m_emp_run + 1 : 0;
            if (m_arr_run >= DEBOUNCE) ndr = 2;
            else if (m_emp_run >= DEBOUNCE) ndr = 3;
        end else if (m_dr == 2) begin
            if (go) ndr = 1;
            else if (!start && !arrived) ndr = 0;
        end else begin
            if (int'(fuel) >= FUEL_RESUME) ndr = 0;
        end
        if (ndr != 1) begin
            m_arr_run = 0;
            m_emp_run = 0;
        end
        m_th = nth;
        m_dr = ndr;
    endfunction

    function automatic logic [13:0] exp_vec();
        logic [7:0] c;
        c = CNT_EN ? ((m_ovh > 255) ? 8'd255 : 8'(m_ovh)) : 8'd0;
        return {m_th != 0, m_dr == 1, 2'(m_dr), 2'(m_th), c};
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic set_temps(input int a0, input int a1, input int a2, input int a3);
        temp = {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        start = 1'b0; arrived = 1'b0; fuel = 8'd50;
        set_temps(25, 25, 25, 25);
        do_reset();
        n_checks++;
        if (w_obs !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_state got=%h exp=%h", w_obs, 14'd0);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (w_obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, w_obs, exp_vec());
            end
        end
    endtask

    task automatic test_thermal_debounce();
        set_temps(25, 25, 95, 25);
        for (int i = 0; i < 3; i++) cycle();
        set_temps(25, 25, 25, 25);
        cycle();
        n_checks++;
        if (th_st !== 2'd0 || w_obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL short_hot got=%h exp_therm=0 model=%h", w_obs, exp_vec());
        end
        set_temps(25, 25, 95, 25);
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if (shut_off !== (i == 3) || w_obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL hot_debounce step=%0d got=%h exp=%h", i, w_obs, exp_vec());
            end
        end
    endtask

    task automatic test_cooldown();
        // HOT -> COOL -> OK after the full cooldown
        set_temps(60, 60, 60, 60);
        for (int i = 0; i < 17; i++) begin
            cycle();
            n_checks++;
            if (w_obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL cooldown step=%0d got=%h exp=%h", i, w_obs, exp_vec());
            end
        end
        n_checks++;
        if (th_st !== 2'd0 || shut_off !== 1'b0) begin
            n_fail++;
            $display("FAIL cooldown_done therm=%0d shut=%0b exp therm=0 shut=0", th_st, shut_off);
        end
        // back to HOT, then reheat at cooldown cycle 8
        set_temps(95, 25, 25, 25);
        for (int i = 0; i < 4; i++) cycle();
        set_temps(60, 60, 60, 60);
        for (int i = 0; i < 9; i++) cycle();
        set_temps(92, 60, 60, 60);
        cycle();
        n_checks++;
        if (th_st !== 2'd1 || w_obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL cool_reheat got=%h exp_therm=1 model=%h", w_obs, exp_vec());
        end
        // warm readings in COOL hold the count
        set_temps(60, 60, 60, 60);
        for (int i = 0; i < 6; i++) cycle();
        set_temps(80, 60, 80, 60);
        for (int i = 0; i < 8; i++) cycle();
        n_checks++;
        if (th_st !== 2'd2 || w_obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL cool_hold got=%h exp_therm=2 model=%h", w_obs, exp_vec());
        end
        set_temps(60, 60, 60, 60);
        for (int i = 0; i < 12; i++) begin
            cycle();
            n_checks++;
            if (w_obs !== exp_vec() || (i < 10 && th_st !== 2'd2) || (i == 11 && th_st !== 2'd0)) begin
                n_fail++;
                $display("FAIL cool_resume step=%0d got=%h exp=%h", i, w_obs, exp_vec());
            end
        end
    endtask

    task automatic test_drive();
        fuel = 8'd50; start = 1'b1; arrived = 1'b0;
        cycle();
        n_checks++;
        if (keep_drv !== 1'b1 || drv_st !== 2'd1) begin
            n_fail++;
            $display("FAIL drive_start keep=%0b state=%0d exp keep=1 state=1", keep_drv, drv_st);
        end
        arrived = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if (keep_drv !== (i != 3) || w_obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL arrive step=%0d got=%h exp=%h", i, w_obs, exp_vec());
            end
        end
        n_checks++;
        if (drv_st !== 2'd2) begin
            n_fail++;
            $display("FAIL parked state=%0d exp=2", drv_st);
        end
        arrived = 1'b0;
        cycle();
        n_checks++;
        if (drv_st !== 2'd1 || keep_drv !== 1'b1) begin
            n_fail++;
            $display("FAIL redrive state=%0d keep=%0b exp state=1 keep=1", drv_st, keep_drv);
        end
    endtask

    task automatic test_priority_empty();
        arrived = 1'b1; fuel = 8'd3;
        for (int i = 0; i < 4; i++) cycle();
        n_checks++;
        if (drv_st !== 2'd2 || w_obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL park_priority got=%h exp_state=2 model=%h", w_obs, exp_vec());
        end
        start = 1'b0; arrived = 1'b0;
        cycle();
        n_checks++;
        if (drv_st !== 2'd0) begin
            n_fail++;
            $display("FAIL parked_to_idle state=%0d exp=0", drv_st);
        end
        fuel = 8'd50; start = 1'b1;
        cycle();
        fuel = 8'd3; start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if (drv_st !== ((i == 3) ? 2'd3 : 2'd1) || w_obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL fuel_empty step=%0d got=%h exp=%h", i, w_obs, exp_vec());
            end
        end
        fuel = 8'd19; start = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        n_checks++;
        if (drv_st !== 2'd3) begin
            n_fail++;
            $display("FAIL empty_hold state=%0d exp=3", drv_st);
        end
        fuel = 8'd20; start = 1'b0;
        cycle();
        n_checks++;
        if (drv_st !== 2'd0 || w_obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL refuel got=%h exp_state=0 model=%h", w_obs, exp_vec());
        end
    endtask

    task automatic test_async_reset();
        fuel = 8'd50; start = 1'b1; arrived = 1'b0;
        set_temps(25, 95, 25, 25);
        for (int i = 0; i < 4; i++) cycle();
        set_temps(60, 60, 60, 60);
        for (int i = 0; i < 6; i++) cycle();
        n_checks++;
        if (drv_st !== 2'd1 || th_st !== 2'd2 || w_obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL pre_reset got=%h exp drive=1 therm=2 model=%h", w_obs, exp_vec());
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (w_obs !== 14'd0) begin
            n_fail++;
            $display("FAIL async_reset got=%h exp=%h", w_obs, 14'd0);
        end
        cycle();
        n_checks++;
        if (w_obs !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_held got=%h exp=%h", w_obs, 14'd0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        cycle();
        n_checks++;
        if (w_obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL post_reset got=%h exp=%h", w_obs, exp_vec());
        end
    endtask

    task automatic test_overheat_cnt();
        start = 1'b0; arrived = 1'b0; fuel = 8'd50;
        set_temps(25, 25, 25, 25);
        do_reset();
        for (int n = 0; n < 303; n++) begin
            set_temps(25, 25, 25, 99);
            for (int i = 0; i < 4; i++) cycle();
            set_temps(60, 60, 60, 60);
            for (int i = 0; i < 17; i++) cycle();
            n_checks++;
            if (w_obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL overheat_loop n=%0d got=%h exp=%h", n, w_obs, exp_vec());
            end
            if (n == 2) begin
                n_checks++;
                if (ovh_cnt !== (CNT_EN ? 8'd3 : 8'd0)) begin
                    n_fail++;
                    $display("FAIL overheat_three got=%0d exp=%0d", ovh_cnt, CNT_EN ? 3 : 0);
                end
            end
        end
        n_checks++;
        if (ovh_cnt !== (CNT_EN ? 8'd255 : 8'd0)) begin
            n_fail++;
            $display("FAIL overheat_sat got=%0d exp=%0d", ovh_cnt, CNT_EN ? 255 : 0);
        end
    endtask

    task automatic test_random();
        int fuel_tab[6] = '{3, 5, 6, 19, 20, 50};
        int v[4];
        bit hot_phase;
        for (int i = 0; i < 2000; i++) begin
            hot_phase = ((i / 150) % 2) == 1;
            for (int k = 0; k < 4; k++) begin
                int r = $urandom_range(0, 99);
                if (r < (hot_phase ? 25 : 1))      v[k] = $urandom_range(90, 255);
                else if (r < (hot_phase ? 50 : 6)) v[k] = $urandom_range(71, 89);
                else                               v[k] = $urandom_range(0, 70);
            end
            set_temps(v[0], v[1], v[2], v[3]);
            arrived = hot_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            fuel    = 8'(fuel_tab[$urandom_range(0, 5)]);
            start   = $urandom_range(0, 1) == 1;
            cycle();
            n_checks++;
            if (w_obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, w_obs, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_thermal_debounce();
        test_cooldown();
        test_drive();
        test_priority_empty();
        test_async_reset();
        test_overheat_cnt();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
